// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with clock deglitch filter, frame check and inter-edge timeout
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] ps2_kbd_code_o,
  output logic       ps2_kbd_strobe_o,
  output logic       ps2_kbd_err_o
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic filt, fall, timeout, data;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt, bcnt_n;
  logic [7:0] sreg, sreg_n, code_n;
  logic par, par_n, strobe_n, err_n;
  assign data    = data_sync[1];
  assign fall    = filt & ~clk_sync[1] & (fcnt == FW'(FILTER_LEN - 1));
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // two-flop synchronizers; idle-high so reset does not look like a clock edge
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  // filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync[1] == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      filt <= clk_sync[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  // cycles since the last edge inside a frame; parks at TIMEOUT_CYCLES once expired
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) tcnt <= '0;
    else if (timeout) tcnt <= TW'(TIMEOUT_CYCLES);
    else if (fall) tcnt <= '0;
    else if (state != IDLE) tcnt <= tcnt + 1'b1;
  // frame decoder: next state, shift register and registered result pulses
  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    sreg_n   = sreg;
    par_n    = par;
    code_n   = ps2_kbd_code_o;
    strobe_n = 1'b0;
    err_n    = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          err_n   = data;
          state_n = data ? IDLE : DATA;
          bcnt_n  = 3'd0;
        end
        DATA: begin
          sreg_n  = {data, sreg[7:1]};
          bcnt_n  = bcnt + 3'd1;
          state_n = (bcnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n   = data;
          state_n = STOP;
        end
        default: begin
          state_n  = IDLE;
          strobe_n = data & (^{sreg, par});
          err_n    = ~strobe_n;
          code_n   = strobe_n ? sreg : ps2_kbd_code_o;
        end
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) begin
      state            <= IDLE;
      bcnt             <= '0;
      sreg             <= '0;
      par              <= 1'b0;
      ps2_kbd_code_o   <= 8'h00;
      ps2_kbd_strobe_o <= 1'b0;
      ps2_kbd_err_o    <= 1'b0;
    end else begin
      state            <= state_n;
      bcnt             <= bcnt_n;
      sreg             <= sreg_n;
      par              <= par_n;
      ps2_kbd_code_o   <= code_n;
      ps2_kbd_strobe_o <= strobe_n;
      ps2_kbd_err_o    <= err_n;
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized PS/2 frames checked against an event-queue model of the receiver
module tb_ps2_kbd_rx;
  localparam int F = 4, T = 200, H = 10;
  logic clk = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] code;
  logic strobe, err;
  int cyc = 0, checks = 0, failures = 0, n_strobe = 0, n_err = 0, last_fall = 0;
  logic [7:0] model_code = 8'h00;
  logic [8:0] exp_q[$];
  int exp_t[$];
  logic pend_valid = 1'b0;
  logic [8:0] pend_e = 9'h0;

  ps2_kbd_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n_i(reset_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .ps2_kbd_code_o(code), .ps2_kbd_strobe_o(strobe), .ps2_kbd_err_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // compare DUT outputs against the expected-event queue every cycle
  always @(posedge clk) begin
    logic [8:0] e;
    int t;
    #1;
    if (!reset_n) begin
      model_code = 8'h00;
      chk("reset_code", code, 8'h00);
      chk("reset_pulses", {strobe, err}, 2'b00);
    end else begin
      chk("exclusive", strobe & err, 0);
      if (strobe | err) begin
        n_strobe += int'(strobe);
        n_err    += int'(err);
        if (exp_q.size() == 0) chk("unexpected_event", {strobe, err}, 2'b00);
        else begin
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          chk("event_kind", err, e[8]);
          if (strobe) begin
            chk("event_code", code, e[7:0]);
            model_code = e[7:0];
          end
          if (t >= 0) chk("event_time", cyc, t);
        end
      end
      chk("code_hold", code, model_code);
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H / 2) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    if (pend_valid) begin
      exp_q.push_back(pend_e);
      exp_t.push_back(last_fall + 2 + F);
      pend_valid = 1'b0;
    end
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (H / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  // a complete frame is good exactly when stop is 1 and data plus parity hold an odd number of ones
  task automatic frame(input logic [7:0] d, input logic p, input logic s);
    logic good;
    good = s && (^{d, p});
    send_frame(mk(d, p, s), 10);
    pend_e = {~good, good ? d : 8'h00};
    pend_valid = 1'b1;
    send_bit(s);
    repeat (2 * H) @(negedge clk);
  endtask

  // an abandoned frame ends in one error exactly T cycles after its last recognised edge
  task automatic partial(input logic [7:0] d, input int n);
    send_frame(mk(d, ~^d, 1'b1), n);
    exp_q.push_back(9'h100);
    exp_t.push_back(last_fall + 2 + F + T);
    repeat (T + F + 20) @(negedge clk);
  endtask

  // idle low pulse with data high: an edge (hence an error) only if it lasts F samples
  task automatic glitch(input int len);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    if (len >= F) begin
      exp_q.push_back(9'h100);
      exp_t.push_back(cyc + 2 + F);
    end
    repeat (len) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2 * F + 6) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("init_code", code, 8'h00);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    frame(8'h1C, 1'b0, 1'b1);
    chk("single_code", code, 8'h1C);
    chk("single_strobes", n_strobe, 1);
    chk("single_errs", n_err, 0);
    frame(8'hF0, 1'b1, 1'b1);
    chk("b2b_first", code, 8'hF0);
    frame(8'h1C, 1'b0, 1'b1);
    chk("b2b_code", code, 8'h1C);
    chk("b2b_strobes", n_strobe, 3);
    frame(8'h1C, 1'b1, 1'b1);
    frame(8'hF0, 1'b1, 1'b0);
    chk("bad_code_kept", code, 8'h1C);
    chk("bad_errs", n_err, 2);
    chk("bad_strobes", n_strobe, 3);
    partial(8'h55, 5);
    chk("timeout_errs", n_err, 3);
    frame(8'h5A, 1'b1, 1'b1);
    chk("after_timeout_code", code, 8'h5A);
    chk("after_timeout_strobes", n_strobe, 4);
    glitch(F - 1);
    chk("short_glitch_errs", n_err, 3);
    glitch(F + 2);
    chk("long_pulse_errs", n_err, 4);
    send_frame(mk(8'h1C, 1'b0, 1'b1), 4);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    exp_t.delete();
    repeat (5) @(negedge clk);
    chk("midframe_reset_code", code, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    frame(8'hF0, 1'b1, 1'b1);
    chk("post_reset_code", code, 8'hF0);
    chk("post_reset_strobes", n_strobe, 5);
    chk("post_reset_errs", n_err, 4);
    repeat (20) begin
      int r;
      logic [7:0] d;
      logic p;
      r = int'($urandom_range(0, 9));
      d = 8'($urandom);
      p = ~^d;
      if (r == 0) frame(d, ~p, 1'b1);
      else if (r == 1) frame(d, p, 1'b0);
      else if (r == 2) partial(d, int'($urandom_range(1, 10)));
      else if (r == 3) glitch(int'($urandom_range(1, 2 * F)));
      else frame(d, p, 1'b1);
    end
    repeat (50) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
